// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU command issuer.
package alu_pkg;
  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } cmd_t;

  // Any opcode with the top bit set has no ALU function behind it.
  function automatic logic op_illegal(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO, wrap-bit pointers, registered-only read visibility (no fall-through).
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives one at a time onto the combinational ALU, returns results in order.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_cin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carrysum,
  input  logic              alu_carrysub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy
);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  cmd_t              alu_cmd_q, alu_cmd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_err_q, rsp_err_d;

  cmd_t fifo_wdata, fifo_rdata;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign fifo_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b, cin: cmd_cin};
  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_cmd_d    = alu_cmd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_cmd_d = fifo_rdata;
          cnt_d     = CNT_INIT;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
          // Illegal ops leave the ALU output floating; never sample it.
          if (op_illegal(alu_cmd_q.op)) begin
            rsp_result_d = '0;
            rsp_carry_d  = 1'b0;
            rsp_err_d    = 1'b1;
          end else if (alu_cmd_q.op == OP_ADD) begin
            rsp_carry_d = alu_carrysum;
          end else if (alu_cmd_q.op == OP_SUB) begin
            rsp_carry_d = alu_carrysub;
          end else begin
            rsp_carry_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_cmd_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_cmd_q.a;
  assign alu_b      = alu_cmd_q.b;
  assign alu_c      = alu_cmd_q.cin;
  assign alu_opcode = alu_cmd_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench: behavioural ALU attached, expected responses queued at command acceptance.
module tb_alu_cmd_issuer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_c, alu_carrysum, alu_carrysub;
  logic [2:0] alu_opcode;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;
  logic [3:0] rsp_result;

  // second instance with a longer settle window
  logic       cmd_valid3, cmd_ready3, alu_c3, alu_carrysum3, alu_carrysub3;
  logic [3:0] alu_a3, alu_b3, alu_result3, pert3;
  logic [2:0] alu_opcode3;
  logic       rsp_valid3, rsp_carry3, rsp_err3, busy3;
  logic       rsp_ready3 = 1'b1;
  logic [3:0] rsp_result3;

  typedef struct packed { logic [3:0] r; logic cs; logic cb; } alu_o_t;
  typedef struct packed { logic [3:0] r; logic c; logic e; } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic alu_o_t alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
    logic [4:0] s, d;
    alu_o_t o;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
    d = {1'b0, a} - {1'b0, b} - {4'b0, c};
    o.cs = s[4];
    o.cb = d[4];
    case (op)
      3'b000:  o.r = s[3:0];
      3'b001:  o.r = d[3:0];
      3'b010:  o.r = a & b;
      3'b011:  o.r = a | b;
      default: begin o.r = 4'b1010; o.cs = 1'b1; o.cb = 1'b1; end
    endcase
    return o;
  endfunction

  function automatic exp_t exp_of(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic c);
    alu_o_t o;
    exp_t   e;
    o = alu_model(op, a, b, c);
    e.r = o.r;
    e.e = 1'b0;
    e.c = (op == 3'b000) ? o.cs : (op == 3'b001) ? o.cb : 1'b0;
    if (op[2]) e = '{r: 4'b0000, c: 1'b0, e: 1'b1};
    return e;
  endfunction

  assign {alu_result, alu_carrysum, alu_carrysub} = alu_model(alu_opcode, alu_a, alu_b, alu_c);

  alu_o_t alu3_o;
  assign alu3_o        = alu_model(alu_opcode3, alu_a3, alu_b3, alu_c3);
  assign alu_result3   = alu3_o.r ^ pert3;
  assign alu_carrysum3 = alu3_o.cs;
  assign alu_carrysub3 = alu3_o.cb;

  alu_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_carrysum(alu_carrysum),
    .alu_carrysub(alu_carrysub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
  );

  alu_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3),
    .alu_opcode(alu_opcode3), .alu_result(alu_result3), .alu_carrysum(alu_carrysum3),
    .alu_carrysub(alu_carrysub3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .rsp_carry(rsp_carry3), .rsp_err(rsp_err3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Responses are compared at the negedge preceding their handshake edge.
  always @(negedge clk) begin
    if (!rst_n) sb_q.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) chk("rsp_extra", 32'(rsp_valid), 32'(0));
        else begin
          mon_e = sb_q.pop_front();
          chk("rsp", 32'({rsp_result, rsp_carry, rsp_err}), 32'(mon_e));
        end
      end
      if (cmd_valid && cmd_ready) sb_q.push_back(exp_of(cmd_op, cmd_a, cmd_b, cmd_cin));
    end
  end

  // Returns at #1 after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic c);
    bit ok = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = c; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(sb_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  logic [11:0] snap3;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b1; pert3 = 4'h0;
    cmd_op = 3'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_cin = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_alu", 32'({alu_opcode, alu_a, alu_b, alu_c}), 32'(0));
    chk("rst_rsp", 32'({rsp_result, rsp_carry, rsp_err}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(cmd_ready), 32'(1));

    // 1: add with latency check
    send(3'b000, 4'b0111, 4'b1001, 1'b0);
    chk("t1_lat0", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    chk("t1_lat1", 32'(rsp_valid), 32'(0));
    chk("t1_alu", 32'({alu_opcode, alu_a, alu_b, alu_c}), 32'({3'b000, 4'b0111, 4'b1001, 1'b0}));
    @(posedge clk); #1;
    chk("t1_lat2", 32'(rsp_valid), 32'(1));
    chk("t1_data", 32'({rsp_result, rsp_carry, rsp_err}), 32'({4'b0000, 1'b1, 1'b0}));
    drain();

    // 2: sub / and / or, back to back
    send(3'b001, 4'b0011, 4'b0101, 1'b0);
    send(3'b010, 4'b1100, 4'b1010, 1'b0);
    send(3'b011, 4'b1100, 4'b1010, 1'b1);
    drain();
    chk("t2_alu_hold", 32'({alu_opcode, alu_a, alu_b, alu_c}), 32'({3'b011, 4'b1100, 4'b1010, 1'b1}));

    // 3: fill the queue with responses blocked
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'(i % 4), 4'(i * 3 + 1), 4'(15 - i), 1'(i));
    chk("t3_rdy4", 32'(cmd_ready), 32'(1));
    send(3'b001, 4'b0000, 4'b0001, 1'b1);
    chk("t3_rdy5", 32'(cmd_ready), 32'(0));
    chk("t3_busy", 32'(busy), 32'(1));
    repeat (3) @(posedge clk); #1;
    chk("t3_hold", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    drain();

    // 4: illegal opcode, then a legal one
    send(3'b101, 4'b1111, 4'b1111, 1'b1);
    send(3'b000, 4'b0001, 4'b0001, 1'b1);
    drain();

    // 5a: reset during DRIVE
    send(3'b000, 4'b0010, 4'b0011, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5d_valid", 32'(rsp_valid), 32'(0));
    chk("t5d_busy", 32'(busy), 32'(0));
    chk("t5d_ready", 32'(cmd_ready), 32'(1));
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t5d_norsp", 32'(rsp_valid), 32'(0));

    // 5b: reset during RESP
    rsp_ready = 1'b0;
    send(3'b011, 4'b0001, 4'b0010, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t5r_inresp", 32'(rsp_valid), 32'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5r_valid", 32'(rsp_valid), 32'(0));
    chk("t5r_busy", 32'(busy), 32'(0));
    chk("t5r_ready", 32'(cmd_ready), 32'(1));
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t5r_norsp", 32'(rsp_valid), 32'(0));

    // 6: SETTLE_CYCLES=3 with the ALU result moving during the window
    cmd_op = 3'b000; cmd_a = 4'b0011; cmd_b = 4'b0100; cmd_cin = 1'b0; cmd_valid3 = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(cmd_ready3), 32'(1));
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    chk("t6_lat0", 32'(rsp_valid3), 32'(0));
    @(posedge clk); #1;
    snap3 = {alu_opcode3, alu_a3, alu_b3, alu_c3};
    chk("t6_alu", 32'(snap3), 32'({3'b000, 4'b0011, 4'b0100, 1'b0}));
    pert3 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t6_stable", 32'({alu_opcode3, alu_a3, alu_b3, alu_c3}), 32'(snap3));
      chk("t6_wait", 32'(rsp_valid3), 32'(0));
      pert3 = (i == 0) ? 4'h6 : 4'h3;
    end
    @(posedge clk); #1;
    chk("t6_lat4", 32'(rsp_valid3), 32'(1));
    chk("t6_data", 32'({rsp_result3, rsp_carry3, rsp_err3}), 32'({4'b0100, 1'b0, 1'b0}));
    pert3 = 4'h0;

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
